alu_operand_sequencer: RTL

- Per-instruction operand gathering stage for the SIMD/SIMF ALU issue path.
- Accepts one issued ALU instruction (up to 3 sources) and, one source at a time, issues the SGPR/VGPR read and drives the 4-bit source-select to the downstream source multiplexer.
- Captures the returned 2048-bit (64 lanes x 32b) operand into src0..src2, then presents the full operand set to execute with a valid/ready handshake.

---
 rtl/alu_operand_sequencer_pkg.sv | 50 +++++
 rtl/alu_opseq_capture_bank.sv | 57 +++++
 rtl/alu_operand_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_pkg.sv
// alu_operand_sequencer_pkg: shared select codes, FSM states and operand
// geometry for the ALU operand sequencer and its capture bank.
package alu_operand_sequencer_pkg;

  localparam int OPSEQ_LANES   = 64;
  localparam int OPSEQ_LANE_W  = 32;
  localparam int OPSEQ_DATA_W  = OPSEQ_LANES * OPSEQ_LANE_W;
  localparam int OPSEQ_WFID_W  = 6;
  localparam int OPSEQ_ADDR_W  = 10;
  localparam int OPSEQ_SADDR_W = 9;
  localparam int OPSEQ_SEL_W   = 4;
  localparam int OPSEQ_CNT_W   = 2;

  typedef enum logic [3:0] {
    SRC_LITERAL = 4'd0,
    SRC_CONST   = 4'd1,
    SRC_VGPR    = 4'd2,
    SRC_SGPR    = 4'd3,
    SRC_VCC_LO  = 4'd4,
    SRC_VCC_HI  = 4'd5,
    SRC_EXEC_LO = 4'd6,
    SRC_EXEC_HI = 4'd7,
    SRC_M0      = 4'd8,
    SRC_VCCZ    = 4'd9,
    SRC_EXECZ   = 4'd10,
    SRC_SCC     = 4'd11
  } src_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } opseq_state_e;

  // Codes 12..15 have no source behind them.
  function automatic logic sel_illegal(
    input logic [OPSEQ_SEL_W-1:0] s
  );
    return s >= 4'd12;
  endfunction

  // Register-file sources need a read cycle before data is valid.
  function automatic logic sel_is_rf(
    input logic [OPSEQ_SEL_W-1:0] s
  );
    return (s == SRC_VGPR) || (s == SRC_SGPR);
  endfunction

endpackage

// File: rtl/alu_opseq_capture_bank.sv
// alu_opseq_capture_bank: three operand registers with clear and indexed write.
// Ports: clk, rst_n (sync, active-low), clr_i, we_i, idx_i, d_i, q0_o..q2_o.
module alu_opseq_capture_bank
  import alu_operand_sequencer_pkg::*;
#(
  parameter int DATA_W = OPSEQ_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr_i,
  input  logic              we_i,
  input  logic [1:0]        idx_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] q0_o,
  output logic [DATA_W-1:0] q1_o,
  output logic [DATA_W-1:0] q2_o
);

  logic [DATA_W-1:0] q0_q;
  logic [DATA_W-1:0] q1_q;
  logic [DATA_W-1:0] q2_q;
  logic              we0;
  logic              we1;
  logic              we2;

  always_comb begin
    we0 = 1'b0;
    we1 = 1'b0;
    we2 = 1'b0;
    if (we_i) begin
      unique case (1'b1)
        (idx_i == 2'd0): we0 = 1'b1;
        (idx_i == 2'd1): we1 = 1'b1;
        (idx_i == 2'd2): we2 = 1'b1;
        default: ;
      endcase
    end
  end

  // Clear wins over a write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      q0_q <= '0;
      q1_q <= '0;
      q2_q <= '0;
    end else begin
      if (we0) q0_q <= d_i;
      if (we1) q1_q <= d_i;
      if (we2) q2_q <= d_i;
    end
  end

  assign q0_o = q0_q;
  assign q1_o = q1_q;
  assign q2_o = q2_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: gathers up to 3 ALU operands one source at a time
// (issue handshake in, SGPR/VGPR reads + mux select out, operand set out
// with valid/ready, flush). ALU_OPSEQ_BYPASS_EN: non-RF sources skip CAPT.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int SEL_W   = OPSEQ_SEL_W,
  parameter int DATA_W  = OPSEQ_DATA_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              issue_valid,
  output logic                              issue_ready,
  input  logic [OPSEQ_WFID_W-1:0]           issue_wfid,
  input  logic [OPSEQ_CNT_W-1:0]            issue_src_cnt,
  input  logic [NUM_SRC*SEL_W-1:0]          issue_src_sel,
  input  logic [NUM_SRC*OPSEQ_ADDR_W-1:0]   issue_src_addr,
  output logic                              sgpr_rd_en,
  output logic [OPSEQ_SADDR_W-1:0]          sgpr_rd_addr,
  output logic                              vgpr_rd_en,
  output logic [OPSEQ_ADDR_W-1:0]           vgpr_rd_addr,
  output logic [SEL_W-1:0]                  source_mux_select,
  input  logic [DATA_W-1:0]                 source_data,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [OPSEQ_WFID_W-1:0]           out_wfid,
  output logic [DATA_W-1:0]                 out_src0,
  output logic [DATA_W-1:0]                 out_src1,
  output logic [DATA_W-1:0]                 out_src2,
  output logic                              out_err
);

  opseq_state_e                    state_q;
  opseq_state_e                    state_d;
  logic [1:0]                      k_q;
  logic [1:0]                      k_d;
  logic [OPSEQ_CNT_W-1:0]          cnt_q;
  logic [OPSEQ_CNT_W-1:0]          cnt_d;
  logic [NUM_SRC*SEL_W-1:0]        sel_q;
  logic [NUM_SRC*SEL_W-1:0]        sel_d;
  logic [NUM_SRC*OPSEQ_ADDR_W-1:0] addr_q;
  logic [NUM_SRC*OPSEQ_ADDR_W-1:0] addr_d;
  logic [OPSEQ_WFID_W-1:0]         wfid_q;
  logic [OPSEQ_WFID_W-1:0]         wfid_d;
  logic                            err_q;
  logic                            err_d;

  logic [SEL_W-1:0]                cur_sel;
  logic [OPSEQ_ADDR_W-1:0]         cur_addr;
  logic                            step;
  logic                            cap_we;
  logic                            cap_clr;
  logic [DATA_W-1:0]               cap_data;

  // Current source's select/address, picked by k.
  always_comb begin
    cur_sel  = '0;
    cur_addr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (k_q == i[1:0]) begin
        cur_sel  = sel_q[i*SEL_W +: SEL_W];
        cur_addr = addr_q[i*OPSEQ_ADDR_W +: OPSEQ_ADDR_W];
      end
    end
  end

  assign cap_data = sel_illegal(cur_sel) ? '0 : source_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      addr_q  <= '0;
      wfid_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wfid_q  <= wfid_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    k_d               = k_q;
    cnt_d             = cnt_q;
    sel_d             = sel_q;
    addr_d            = addr_q;
    wfid_d            = wfid_q;
    err_d             = err_q;
    step              = 1'b0;
    cap_we            = 1'b0;
    cap_clr           = 1'b0;
    issue_ready       = 1'b0;
    out_valid         = 1'b0;
    source_mux_select = '0;
    vgpr_rd_en        = 1'b0;
    vgpr_rd_addr      = '0;
    sgpr_rd_en        = 1'b0;
    sgpr_rd_addr      = '0;

    unique case (state_q)
      ST_IDLE: begin
        issue_ready = 1'b1;
        if (issue_valid) begin
          wfid_d  = issue_wfid;
          cnt_d   = issue_src_cnt;
          sel_d   = issue_src_sel;
          addr_d  = issue_src_addr;
          err_d   = 1'b0;
          cap_clr = 1'b1;
          k_d     = '0;
          state_d = (issue_src_cnt == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        source_mux_select = cur_sel;
        if (cur_sel == SRC_VGPR) begin
          vgpr_rd_en   = 1'b1;
          vgpr_rd_addr = cur_addr;
        end
        if (cur_sel == SRC_SGPR) begin
          sgpr_rd_en   = 1'b1;
          sgpr_rd_addr = cur_addr[OPSEQ_SADDR_W-1:0];
        end
`ifdef ALU_OPSEQ_BYPASS_EN
        // Mux already drives non-RF data this cycle.
        if (!sel_is_rf(cur_sel)) begin
          step = 1'b1;
        end else begin
          state_d = ST_CAPT;
        end
`else
        state_d = ST_CAPT;
`endif
      end
      ST_CAPT: begin
        source_mux_select = cur_sel;
        step              = 1'b1;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Capture current source, then advance or finish.
    if (step) begin
      cap_we = 1'b1;
      if (sel_illegal(cur_sel)) err_d = 1'b1;
      if (k_q == cnt_q - 2'd1) begin
        state_d = ST_DONE;
      end else begin
        k_d     = k_q + 2'd1;
        state_d = ST_READ;
      end
    end

    // Flush drops the instruction and anything captured so far.
    if (flush && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      k_d     = '0;
      cap_we  = 1'b0;
      cap_clr = 1'b1;
      err_d   = 1'b0;
    end
  end

  alu_opseq_capture_bank #(
    .DATA_W (DATA_W)
  ) u_bank (
    .clk   (clk),
    .rst_n (rst),
    .clr_i (cap_clr),
    .we_i  (cap_we),
    .idx_i (k_q),
    .d_i   (cap_data),
    .q0_o  (out_src0),
    .q1_o  (out_src1),
    .q2_o  (out_src2)
  );

  assign out_wfid = wfid_q;
  assign out_err  = err_q;

endmodule
